// File: rtl/dsp_fetch_sequencer_pkg.sv
// Shared definitions for the DSP fetch sequencer.
//   MEM_ADDR_LEN      : instruction address width
//   REG_WORD_LEN      : instruction / register word width
//   FETCH_QUEUE_DEPTH : entries in the fetched-word queue feeding decode
//   fetch_state_e     : sequencer FSM encoding
package dsp_fetch_sequencer_pkg;

   localparam int unsigned MEM_ADDR_LEN      = 16;
   localparam int unsigned REG_WORD_LEN      = 16;
   localparam int unsigned FETCH_QUEUE_DEPTH = 2;

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StRedirect = 2'd1,
      StHalted   = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/dsp_fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs between imem and decode.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   clear_i               : drop all entries (redirect); wins over push/pop
//   push_i, push_pc_i,
//   push_instr_i          : enqueue one word and its address
//   pop_i                 : dequeue head (ignored when empty)
//   head_pc_o,
//   head_instr_o          : oldest entry, stable until popped
//   empty_o, cnt_o        : occupancy status
module dsp_fetch_queue
   import dsp_fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W  = MEM_ADDR_LEN,
   parameter int unsigned INSTR_W = REG_WORD_LEN
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic               push_i,
   input  logic [ADDR_W-1:0]  push_pc_i,
   input  logic [INSTR_W-1:0] push_instr_i,
   input  logic               pop_i,
   output logic [ADDR_W-1:0]  head_pc_o,
   output logic [INSTR_W-1:0] head_instr_o,
   output logic               empty_o,
   output logic [1:0]         cnt_o
);

   logic [ADDR_W-1:0]  pc_mem_q    [2];
   logic [ADDR_W-1:0]  pc_mem_d    [2];
   logic [INSTR_W-1:0] instr_mem_q [2];
   logic [INSTR_W-1:0] instr_mem_d [2];
   logic               wr_q, wr_d;
   logic               rd_q, rd_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               full, do_push, do_pop;

   always_comb begin
      full        = (cnt_q == 2'(FETCH_QUEUE_DEPTH));
      do_pop      = pop_i && (cnt_q != 2'd0);
      // Push into a full queue is legal only when the head leaves this cycle.
      do_push     = push_i && (!full || do_pop);
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      if (clear_i) begin
         wr_d  = 1'b0;
         rd_d  = 1'b0;
         cnt_d = 2'd0;
      end else begin
         if (do_push) begin
            pc_mem_d[wr_q]    = push_pc_i;
            instr_mem_d[wr_q] = push_instr_i;
            wr_d              = ~wr_q;
         end
         if (do_pop) begin
            rd_d = ~rd_q;
         end
         cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
   end

   // The credit limit upstream must make overflow impossible.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !clear_i) begin
         assert (!(push_i && full && !pop_i));
      end
   end

   assign head_pc_o    = pc_mem_q[rd_q];
   assign head_instr_o = instr_mem_q[rd_q];
   assign empty_o      = (cnt_q == 2'd0);
   assign cnt_o        = cnt_q;

endmodule

// File: rtl/dsp_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer for the DSP core.
// Issues in-order imem requests under a credit limit, queues returned words for decode,
// and on a taken jump redirects the pc, pulses flush and discards stale in-flight fetches.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   jump_flag, jump_addr          : taken-branch redirect from the branch unit
//   halt                          : stop issuing; in-flight fetches still drain
//   imem_req/addr/gnt             : fetch request handshake
//   imem_rvalid/rdata             : in-order read responses
//   instr_valid/ready, instr,
//   instr_pc                      : fetched word handshake to decode
//   flush                         : one-cycle kill of younger instructions after a jump
//   busy                          : requests outstanding or words queued
module dsp_fetch_sequencer
   import dsp_fetch_sequencer_pkg::*;
#(
   parameter int unsigned       ADDR_W    = MEM_ADDR_LEN,
   parameter int unsigned       INSTR_W   = REG_WORD_LEN,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   // Must not exceed the queue depth, otherwise the queue could overflow.
   parameter int unsigned       MAX_OUTST = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               jump_flag,
   input  logic [ADDR_W-1:0]  jump_addr,
   input  logic               halt,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               flush,
   output logic               busy
);

   localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CntW-1:0]    outst_q, outst_d;
   logic [CntW-1:0]    drop_q, drop_d;
   logic [CntW:0]      used;
   logic               req_acc;
   logic               q_push, q_pop, q_clear, q_empty;
   logic [1:0]         q_cnt;
   logic [ADDR_W-1:0]  rsp_pc;

   always_comb begin
      instr_valid = !q_empty;
      q_pop       = instr_valid && instr_ready;
      // A word leaving the queue this cycle frees a credit immediately, which keeps
      // single-cycle imem streaming at one word per cycle.
      used        = {1'b0, outst_q} + (CntW+1)'(q_cnt) - (CntW+1)'(q_pop);
      imem_req    = !rst && !halt && (state_q != StHalted)
                    && (used < (CntW+1)'(MAX_OUTST));
      imem_addr   = pc_q;
      req_acc     = imem_req && imem_gnt;
      // Live requests are the newest ones, addressed pc-outst .. pc-1, so the
      // oldest live response belongs to pc - outst when nothing is left to drop.
      rsp_pc      = pc_q - ADDR_W'(outst_q);
      flush       = (state_q == StRedirect);
      busy        = (outst_q != '0) || !q_empty;

      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      q_push  = 1'b0;
      q_clear = 1'b0;
      outst_d = outst_q + CntW'(req_acc) - CntW'(imem_rvalid);

      if (jump_flag) begin
         // Everything still in flight after this cycle, including a grant taken
         // right now, predates the jump and must be thrown away.
         state_d = StRedirect;
         pc_d    = jump_addr;
         q_clear = 1'b1;
         drop_d  = outst_d;
      end else begin
         if (req_acc) begin
            pc_d = pc_q + ADDR_W'(1);
         end
         if (imem_rvalid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CntW'(1);
            end else begin
               q_push = 1'b1;
            end
         end
         unique case (state_q)
            StRun:      if (halt) state_d = StHalted;
            StRedirect: state_d = halt ? StHalted : StRun;
            StHalted:   if (!halt) state_d = StRun;
            default:    state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

   dsp_fetch_queue #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_queue (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (q_clear),
      .push_i       (q_push),
      .push_pc_i    (rsp_pc),
      .push_instr_i (imem_rdata),
      .pop_i        (q_pop),
      .head_pc_o    (instr_pc),
      .head_instr_o (instr),
      .empty_o      (q_empty),
      .cnt_o        (q_cnt)
   );

endmodule

// File: tb/tb_dsp_fetch_sequencer.sv
module tb_dsp_fetch_sequencer;

   localparam int unsigned AW = 16;
   localparam int unsigned IW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          jump_flag;
   logic [AW-1:0] jump_addr;
   logic          halt;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [IW-1:0] imem_rdata;
   logic          instr_valid;
   logic          instr_ready;
   logic [IW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          flush;
   logic          busy;

   always #5 clk = ~clk;

   dsp_fetch_sequencer #(
      .ADDR_W    (AW),
      .INSTR_W   (IW),
      .RESET_PC  (16'h0000),
      .MAX_OUTST (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .jump_flag   (jump_flag),
      .jump_addr   (jump_addr),
      .halt        (halt),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .flush       (flush),
      .busy        (busy)
   );

   int total = 0;
   int bad   = 0;

   // imem model: grants limited by a budget, constant response latency (in order).
   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } pend_t;
   pend_t         pend_q[$];
   int            grant_count = 0;
   int            grant_limit = 0;
   int            edge_cnt    = 0;
   int            lat         = 1;

   // Expected pcs in delivery order.
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] mon_exp;

   function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   assign imem_gnt = imem_req && (grant_count < grant_limit);

   always @(posedge clk) begin
      if (rst) begin
         pend_q.delete();
         imem_rvalid <= 1'b0;
         imem_rdata  <= '0;
      end else begin
         edge_cnt++;
         if (imem_req && imem_gnt) begin
            pend_q.push_back('{addr: imem_addr, due: edge_cnt + lat - 1});
            grant_count++;
         end
         if (pend_q.size() != 0 && pend_q[0].due <= edge_cnt) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= word_of(pend_q[0].addr);
            void'(pend_q.pop_front());
         end else begin
            imem_rvalid <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every word accepted by decode is checked against the scoreboard.
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got pc 0x%0h want none", instr_pc);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("instr_pc", 32'(instr_pc), 32'(mon_exp));
            chk("instr", 32'(instr), 32'(word_of(mon_exp)));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic allow(input int n);
      grant_limit += n;
   endtask

   task automatic expect_run(input logic [AW-1:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + AW'(i));
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(exp_q.size() == 0 && busy === 1'b0), 32'd1);
   endtask

   initial begin
      rst         = 1'b1;
      jump_flag   = 1'b0;
      jump_addr   = '0;
      halt        = 1'b0;
      instr_ready = 1'b1;
      repeat (3) cyc();

      // Reset state
      @(negedge clk);
      chk("rst_req",   32'(imem_req),    32'd0);
      chk("rst_addr",  32'(imem_addr),   32'h0000);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_flush", 32'(flush),       32'd0);
      chk("rst_busy",  32'(busy),        32'd0);

      // Straight-line: one word per cycle, pc 0.. from the third cycle after release
      allow(6);
      expect_run(16'h0000, 6);
      cyc(); rst = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      chk("sl_valid0", 32'(instr_valid), 32'd1);
      chk("sl_pc0",    32'(instr_pc),    32'h0000);
      for (int i = 1; i < 4; i++) begin
         cyc();
         @(negedge clk);
         chk("sl_valid", 32'(instr_valid), 32'd1);
         chk("sl_pc",    32'(instr_pc),    32'(i));
      end
      drain("sl_drain");

      // Jump with single-cycle imem: flush, refetch at target, instr three cycles later
      cyc(); jump_flag = 1'b1; jump_addr = 16'h0040; expect_run(16'h0040, 3);
      cyc(); jump_flag = 1'b0; allow(3);
      @(negedge clk);
      chk("ja_flush", 32'(flush),     32'd1);
      chk("ja_req",   32'(imem_req),  32'd1);
      chk("ja_addr",  32'(imem_addr), 32'h0040);
      cyc();
      @(negedge clk);
      chk("ja_flush_end", 32'(flush), 32'd0);
      cyc();
      @(negedge clk);
      chk("ja_valid", 32'(instr_valid), 32'd1);
      chk("ja_pc",    32'(instr_pc),    32'h0040);
      drain("ja_drain");

      // Jump with two stale fetches in flight (3-cycle imem): both must be dropped
      cyc(); lat = 3; allow(2);
      cyc();
      cyc(); jump_flag = 1'b1; jump_addr = 16'h0080; expect_run(16'h0080, 3);
      @(negedge clk);
      chk("jb_credit_full", 32'(imem_req), 32'd0);
      cyc(); jump_flag = 1'b0; allow(3);
      @(negedge clk);
      chk("jb_flush",   32'(flush),    32'd1);
      chk("jb_req_blk", 32'(imem_req), 32'd0);
      chk("jb_busy",    32'(busy),     32'd1);
      cyc();
      @(negedge clk);
      chk("jb_flush_end", 32'(flush),     32'd0);
      chk("jb_req",       32'(imem_req),  32'd1);
      chk("jb_addr",      32'(imem_addr), 32'h0080);
      drain("jb_drain");
      lat = 1;

      // Backpressure: queue fills, requests stop, head held stable
      cyc(); instr_ready = 1'b0; allow(4); expect_run(16'h0083, 4);
      cyc();
      cyc();
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         chk("bp_valid", 32'(instr_valid), 32'd1);
         chk("bp_pc",    32'(instr_pc),    32'h0083);
         chk("bp_instr", 32'(instr),       32'(word_of(16'h0083)));
         chk("bp_req",   32'(imem_req),    32'd0);
      end
      cyc(); instr_ready = 1'b1;
      drain("bp_drain");

      // Address wrap
      cyc(); jump_flag = 1'b1; jump_addr = 16'hFFFE; expect_run(16'hFFFE, 3);
      cyc(); jump_flag = 1'b0; allow(3);
      drain("wrap_drain");

      // Halt with one fetch outstanding, then resume at the next pc
      cyc(); lat = 3; allow(1); expect_run(16'h0001, 1);
      cyc(); halt = 1'b1;
      @(negedge clk);
      chk("halt_req",  32'(imem_req), 32'd0);
      chk("halt_busy", 32'(busy),     32'd1);
      cyc();
      cyc();
      cyc();
      @(negedge clk);
      chk("halt_valid", 32'(instr_valid), 32'd1);
      chk("halt_pc",    32'(instr_pc),    32'h0001);
      cyc();
      cyc();
      @(negedge clk);
      chk("halt_busy_low", 32'(busy),     32'd0);
      chk("halt_req_off",  32'(imem_req), 32'd0);
      cyc(); halt = 1'b0; allow(2); expect_run(16'h0002, 2);
      @(negedge clk);
      chk("resume_req_wait", 32'(imem_req), 32'd0);
      cyc();
      @(negedge clk);
      chk("resume_req",  32'(imem_req),  32'd1);
      chk("resume_addr", 32'(imem_addr), 32'h0002);
      drain("halt_drain");
      lat = 1;

      // Reset mid-run with a full queue
      cyc(); instr_ready = 1'b0; allow(2);
      repeat (3) cyc();
      @(negedge clk);
      chk("mr_full_valid", 32'(instr_valid), 32'd1);
      chk("mr_full_busy",  32'(busy),        32'd1);
      cyc(); rst = 1'b1;
      cyc();
      @(negedge clk);
      chk("mr_valid", 32'(instr_valid), 32'd0);
      chk("mr_addr",  32'(imem_addr),   32'h0000);
      chk("mr_busy",  32'(busy),        32'd0);
      chk("mr_req",   32'(imem_req),    32'd0);
      chk("mr_flush", 32'(flush),       32'd0);
      instr_ready = 1'b1; allow(2); expect_run(16'h0000, 2);
      cyc(); rst = 1'b0;
      drain("mr_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
